mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 The block SHALL have these ports: rstn  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have these ports: Op  in  6  opcode from the instruction register; Funct  in  6  funct from the instruction register; Zero  in  1  ALU zero flag; mem_ready  in  1  data-memory access complete.
REQ-004 The block SHALL have these ports: PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc  out  1 each; ALUOp  out  4; NPCOp, GPRSel, WDSel  out  2 each; state  out  3; halted  out  1; instr_cnt  out  32.
REQ-005 Encodings SHALL be as follows:
- NPCOp: PLUS4 00, BRANCH 01, JUMP 10, JUMPR 11.
- GPRSel: RD 00, RT 01, R31 10.
- WDSel: ALU 00, MEM 01, PC 10.
- ALUOp: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, NOR 0111, LUI 1001.

Function
REQ-006 The supported instructions SHALL be:
- R-type: add, sub, and, or, slt, sltu, addu, subu, nor, jr, jalr.
- I-type: addi, ori, andi, slti, lui, lw, sw, beq.
- J-type: j, jal.
- Any other Op/Funct combination is illegal.
REQ-007 The state register SHALL use these encodings: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 111. The `state` output SHALL mirror this register.
REQ-008 All outputs SHALL be decoded combinationally from state, Op, Funct, Zero and mem_ready. Every strobe not listed for a state SHALL be 0, ALUOp SHALL be NOP, and the 2-bit selects SHALL be 00.
REQ-009 FETCH: IRWrite=1; next state DECODE.
REQ-010 DECODE handles jumps and illegal instructions, then routes everything else:
- j: PCWrite=1, NPCOp=JUMP.
- jal: PCWrite=1, NPCOp=JUMP, RegWrite=1, GPRSel=R31, WDSel=PC.
- jr: PCWrite=1, NPCOp=JUMPR.
- jalr: PCWrite=1, NPCOp=JUMPR, RegWrite=1, GPRSel=RD, WDSel=PC.
- j, jal, jr and jalr SHALL go to FETCH next.
- Illegal: next state HALT, with no strobe asserted.
- All other instructions: next state EXEC.
REQ-011 EXEC SHALL drive ALUOp per instruction and then branch on instruction class:
- ALUOp per instruction: add, addu, addi, lw, sw = ADD; sub, subu, beq = SUB; and, andi = AND; or, ori = OR; slt, slti = SLT; sltu = SLTU; nor = NOR; lui = LUI.
- ALUSrc=1 for lw, sw, addi, ori, andi, slti, lui.
- EXTOp=1 for addi, lw, sw, andi, slti, lui.
- beq: PCWrite=1; NPCOp=BRANCH if Zero=1, otherwise PLUS4; next state FETCH.
- lw and sw: next state MEM.
- All others: next state WB.
REQ-012 MEM SHALL hold MemRead=1 (lw) or MemWrite=1 (sw) on every cycle until mem_ready=1, staying in MEM while mem_ready=0.
- When mem_ready=1 for sw: PCWrite=1, NPCOp=PLUS4, next state FETCH.
- When mem_ready=1 for lw: next state WB.
REQ-013 WB SHALL drive RegWrite=1, PCWrite=1 and NPCOp=PLUS4, with these selects:
- lw: WDSel=MEM, GPRSel=RT.
- I-type ALU instructions: WDSel=ALU, GPRSel=RT.
- R-type: WDSel=ALU, GPRSel=RD.
- Next state FETCH.
REQ-014 HALT SHALL be sticky until reset: halted=1 and all strobes 0.
REQ-015 Latency SHALL be 2 cycles for j/jal/jr/jalr, 3 for beq, 4 for R-type and I-type ALU instructions, 4+N for sw and 5+N for lw, where N = number of MEM cycles with mem_ready=0.
REQ-016 PCWrite SHALL be asserted exactly once per retired instruction, always in that instruction's final cycle.
REQ-017 If mem_ready=1 in any state other than MEM, it SHALL be ignored.

Reset
REQ-018 On a rising clk with rstn=0, state SHALL become FETCH, halted SHALL become 0 and instr_cnt SHALL become 0. This SHALL take priority over any transition, including mid-MEM and HALT.
REQ-019 While rstn=0, PCWrite, IRWrite, RegWrite, MemRead and MemWrite SHALL be forced to 0.

Configuration
REQ-020 With MC_CTRL_PERF_CNT_EN defined, instr_cnt SHALL increment by 1 on every clock edge where PCWrite=1 and rstn=1, wrapping from 0xFFFFFFFF to 0x00000000.
REQ-021 Without MC_CTRL_PERF_CNT_EN, instr_cnt SHALL be constant 0, with no counter register synthesized.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add (Op=000000, Funct=100000) after reset -> states 000,001,010,100,000; EXEC ALUOp=0001; WB RegWrite=1, GPRSel=00, WDSel=00, PCWrite=1.
- lw (Op=100011), mem_ready=0 for 2 MEM cycles -> MemRead=1 for 3 cycles; WB WDSel=01, GPRSel=01; total 7 cycles.
- beq (Op=000100): Zero=1 -> EXEC NPCOp=01, PCWrite=1; Zero=0 -> NPCOp=00; both return to FETCH after 3 cycles.
- jal (Op=000011) -> DECODE: RegWrite=1, GPRSel=10, WDSel=10, NPCOp=10, PCWrite=1; next state 000.
- Op=111111 -> HALT (111), halted=1 held 10 cycles; rstn=0 for one edge -> state 000, halted=0.
- With macro: sw + addi + j -> instr_cnt=3; rstn=0 asserted mid-MEM -> instr_cnt=0, MemWrite=0, state 000.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Bus between the multicycle controller and its datapath: instruction fields
// and status come in, and strobes, selects and status go out.
interface mc_ctrl_if;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic        Zero;
   logic        mem_ready;
   logic        PCWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        EXTOp;
   logic        ALUSrc;
   logic [3:0]  ALUOp;
   logic [1:0]  NPCOp;
   logic [1:0]  GPRSel;
   logic [1:0]  WDSel;
   logic [2:0]  state;
   logic        halted;
   logic [31:0] instr_cnt;

   modport master (
      input  Op, Funct, Zero, mem_ready,
      output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc,
             ALUOp, NPCOp, GPRSel, WDSel, state, halted, instr_cnt
   );

   modport slave (
      output Op, Funct, Zero, mem_ready,
      input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc,
             ALUOp, NPCOp, GPRSel, WDSel, state, halted, instr_cnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky HALT.
// Define MC_CTRL_PERF_CNT_EN to enable the retired-instruction counter on instr_cnt.
module mc_ctrl (
   input  logic         clk,
   input  logic         rstn,
   mc_ctrl_if.master    bus
);
   typedef enum logic [2:0] {
      S_FETCH = 3'b000, S_DECODE = 3'b001, S_EXEC = 3'b010,
      S_MEM   = 3'b011, S_WB     = 3'b100, S_HALT = 3'b111
   } state_t;

   typedef enum logic [3:0] {
      I_ILLEGAL = 4'd0, I_RALU = 4'd1, I_IALU = 4'd2, I_LW  = 4'd3, I_SW   = 4'd4,
      I_BEQ     = 4'd5, I_J    = 4'd6, I_JAL  = 4'd7, I_JR  = 4'd8, I_JALR = 4'd9
   } kind_t;

   localparam logic [3:0] ALU_NOP = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB  = 4'b0010,
                          ALU_AND = 4'b0011, ALU_OR  = 4'b0100, ALU_SLT  = 4'b0101,
                          ALU_SLTU = 4'b0110, ALU_NOR = 4'b0111, ALU_LUI = 4'b1001;
   localparam logic [1:0] NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JUMPR = 2'b11;
   localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_R31 = 2'b10;
   localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;

   state_t     state_r;
   kind_t      kind_s;
   logic [3:0] dec_alu_s;
   logic       dec_src_s, dec_ext_s;
   logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;
   logic       ext_op_s, alu_src_s;
   logic [3:0] alu_op_s;
   logic [1:0] npc_op_s, gpr_sel_s, wd_sel_s;

   // Classify the instruction held in IR and pick its ALU operation and operand controls.
   always_comb begin
      kind_s    = I_ILLEGAL;
      dec_alu_s = ALU_NOP;
      dec_src_s = 1'b0;
      dec_ext_s = 1'b0;
      case (bus.Op)
         6'b000000: begin
            case (bus.Funct)
               6'b100000, 6'b100001: begin kind_s = I_RALU; dec_alu_s = ALU_ADD;  end
               6'b100010, 6'b100011: begin kind_s = I_RALU; dec_alu_s = ALU_SUB;  end
               6'b100100:            begin kind_s = I_RALU; dec_alu_s = ALU_AND;  end
               6'b100101:            begin kind_s = I_RALU; dec_alu_s = ALU_OR;   end
               6'b100111:            begin kind_s = I_RALU; dec_alu_s = ALU_NOR;  end
               6'b101010:            begin kind_s = I_RALU; dec_alu_s = ALU_SLT;  end
               6'b101011:            begin kind_s = I_RALU; dec_alu_s = ALU_SLTU; end
               6'b001000:            kind_s = I_JR;
               6'b001001:            kind_s = I_JALR;
               default:              kind_s = I_ILLEGAL;
            endcase
         end
         6'b001000: begin kind_s = I_IALU; dec_alu_s = ALU_ADD; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b001101: begin kind_s = I_IALU; dec_alu_s = ALU_OR;  dec_src_s = 1'b1; end
         6'b001100: begin kind_s = I_IALU; dec_alu_s = ALU_AND; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b001010: begin kind_s = I_IALU; dec_alu_s = ALU_SLT; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b001111: begin kind_s = I_IALU; dec_alu_s = ALU_LUI; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b100011: begin kind_s = I_LW;   dec_alu_s = ALU_ADD; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b101011: begin kind_s = I_SW;   dec_alu_s = ALU_ADD; dec_src_s = 1'b1; dec_ext_s = 1'b1; end
         6'b000100: begin kind_s = I_BEQ;  dec_alu_s = ALU_SUB; end
         6'b000010: kind_s = I_J;
         6'b000011: kind_s = I_JAL;
         default:   kind_s = I_ILLEGAL;
      endcase
   end

   // State sequencing; reset wins over every transition, including HALT and a pending MEM access.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= S_FETCH;
      end else begin
         case (state_r)
            S_FETCH:  state_r <= S_DECODE;
            S_DECODE: begin
               case (kind_s)
                  I_ILLEGAL:               state_r <= S_HALT;
                  I_J, I_JAL, I_JR, I_JALR: state_r <= S_FETCH;
                  default:                 state_r <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               case (kind_s)
                  I_BEQ:       state_r <= S_FETCH;
                  I_LW, I_SW:  state_r <= S_MEM;
                  default:     state_r <= S_WB;
               endcase
            end
            S_MEM: begin
               if (bus.mem_ready) state_r <= (kind_s == I_LW) ? S_WB : S_FETCH;
               else               state_r <= S_MEM;
            end
            S_WB:    state_r <= S_FETCH;
            S_HALT:  state_r <= S_HALT;
            default: state_r <= S_FETCH;
         endcase
      end
   end

   // Per-state control decode; anything a state does not drive stays at zero / NOP / 00.
   always_comb begin
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      ext_op_s    = 1'b0;
      alu_src_s   = 1'b0;
      alu_op_s    = ALU_NOP;
      npc_op_s    = NPC_PLUS4;
      gpr_sel_s   = GPR_RD;
      wd_sel_s    = WD_ALU;
      case (state_r)
         S_FETCH: ir_write_s = 1'b1;
         S_DECODE: begin
            case (kind_s)
               I_J:    begin pc_write_s = 1'b1; npc_op_s = NPC_JUMP; end
               I_JAL:  begin pc_write_s = 1'b1; npc_op_s = NPC_JUMP; reg_write_s = 1'b1;
                             gpr_sel_s = GPR_R31; wd_sel_s = WD_PC; end
               I_JR:   begin pc_write_s = 1'b1; npc_op_s = NPC_JUMPR; end
               I_JALR: begin pc_write_s = 1'b1; npc_op_s = NPC_JUMPR; reg_write_s = 1'b1;
                             gpr_sel_s = GPR_RD; wd_sel_s = WD_PC; end
               default: pc_write_s = 1'b0;
            endcase
         end
         S_EXEC: begin
            alu_op_s  = dec_alu_s;
            alu_src_s = dec_src_s;
            ext_op_s  = dec_ext_s;
            if (kind_s == I_BEQ) begin
               pc_write_s = 1'b1;
               npc_op_s   = bus.Zero ? NPC_BRANCH : NPC_PLUS4;
            end else begin
               pc_write_s = 1'b0;
            end
         end
         S_MEM: begin
            mem_read_s  = (kind_s == I_LW);
            mem_write_s = (kind_s == I_SW);
            if (bus.mem_ready && (kind_s == I_SW)) pc_write_s = 1'b1;
            else                                   pc_write_s = 1'b0;
         end
         S_WB: begin
            reg_write_s = 1'b1;
            pc_write_s  = 1'b1;
            if (kind_s == I_LW) begin
               wd_sel_s  = WD_MEM;
               gpr_sel_s = GPR_RT;
            end else if (kind_s == I_RALU) begin
               gpr_sel_s = GPR_RD;
            end else begin
               gpr_sel_s = GPR_RT;
            end
         end
         default: pc_write_s = 1'b0;
      endcase
   end

   // Strobes are held low while reset is asserted, whatever the state register holds.
   assign bus.PCWrite  = pc_write_s  & rstn;
   assign bus.IRWrite  = ir_write_s  & rstn;
   assign bus.RegWrite = reg_write_s & rstn;
   assign bus.MemRead  = mem_read_s  & rstn;
   assign bus.MemWrite = mem_write_s & rstn;
   assign bus.EXTOp    = ext_op_s;
   assign bus.ALUSrc   = alu_src_s;
   assign bus.ALUOp    = alu_op_s;
   assign bus.NPCOp    = npc_op_s;
   assign bus.GPRSel   = gpr_sel_s;
   assign bus.WDSel    = wd_sel_s;
   assign bus.state    = state_r;
   assign bus.halted   = (state_r == S_HALT);

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] instr_cnt_r;

   // Retired-instruction counter: one PCWrite per instruction, wraps naturally.
   always_ff @(posedge clk) begin
      if (!rstn)           instr_cnt_r <= 32'd0;
      else if (pc_write_s) instr_cnt_r <= instr_cnt_r + 32'd1;
      else                 instr_cnt_r <= instr_cnt_r;
   end

   assign bus.instr_cnt = instr_cnt_r;
`else
   assign bus.instr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction reference model expands each
// instruction into its expected cycle-by-cycle control vector, checked against the DUT.
module tb_mc_ctrl;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mc_ctrl_if bus();
   mc_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

   int checks = 0;
   int failures = 0;
   logic [31:0] cnt_model = 32'd0;

   typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_JALR} kind_e;
   typedef struct {
      string      nm;
      logic [5:0] op;
      logic [5:0] funct;
      kind_e      kind;
      logic [3:0] alu;
      logic       src;
      logic       ext;
   } ins_t;

   ins_t tbl[$];
   logic [20:0] exp_q[$];
   int          mr_q[$];

   // vector: state, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrc, ALUOp, NPCOp, GPRSel, WDSel, halted
   function automatic logic [20:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic ext, input logic src, input logic [3:0] alu,
                                      input logic [1:0] npc, input logic [1:0] gs,
                                      input logic [1:0] wd, input logic h);
      return {st, pcw, irw, rw, mr, mw, ext, src, alu, npc, gs, wd, h};
   endfunction

   function automatic logic [20:0] obs();
      return {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite,
              bus.EXTOp, bus.ALUSrc, bus.ALUOp, bus.NPCOp, bus.GPRSel, bus.WDSel, bus.halted};
   endfunction

   function automatic logic [31:0] exp_cnt();
`ifdef MC_CTRL_PERF_CNT_EN
      return cnt_model;
`else
      return 32'd0;
`endif
   endfunction

   task automatic add_ins(input string nm, input logic [5:0] op, input logic [5:0] f,
                          input kind_e k, input logic [3:0] alu, input logic src, input logic ext);
      ins_t t;
      t.nm = nm; t.op = op; t.funct = f; t.kind = k; t.alu = alu; t.src = src; t.ext = ext;
      tbl.push_back(t);
   endtask

   function automatic ins_t find(input string nm);
      foreach (tbl[i]) if (tbl[i].nm == nm) return tbl[i];
      return tbl[0];
   endfunction

   function automatic int latency(input kind_e k, input int n);
      case (k)
         K_J, K_JAL, K_JR, K_JALR: return 2;
         K_BEQ:                    return 3;
         K_SW:                     return 4 + n;
         K_LW:                     return 5 + n;
         default:                  return 4;
      endcase
   endfunction

   // Expand one instruction into its expected cycles; mr_q: -1 random, else the mem_ready value.
   task automatic build(input ins_t in, input logic z, input int n);
      logic is_lw, is_sw;
      is_lw = (in.kind == K_LW);
      is_sw = (in.kind == K_SW);
      exp_q.delete(); mr_q.delete();
      exp_q.push_back(mk(3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(-1);
      case (in.kind)
         K_J:    begin exp_q.push_back(mk(3'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b10,2'b00,2'b00,1'b0)); mr_q.push_back(-1); end
         K_JAL:  begin exp_q.push_back(mk(3'd1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,2'b10,2'b10,2'b10,1'b0)); mr_q.push_back(-1); end
         K_JR:   begin exp_q.push_back(mk(3'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b11,2'b00,2'b00,1'b0)); mr_q.push_back(-1); end
         K_JALR: begin exp_q.push_back(mk(3'd1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,2'b11,2'b00,2'b10,1'b0)); mr_q.push_back(-1); end
         default: begin
            exp_q.push_back(mk(3'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(-1);
            exp_q.push_back(mk(3'd2,(in.kind == K_BEQ),1'b0,1'b0,1'b0,1'b0,in.ext,in.src,in.alu,
                               ((in.kind == K_BEQ) && z) ? 2'b01 : 2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(-1);
            if (is_lw || is_sw) begin
               for (int i = 0; i < n; i++) begin
                  exp_q.push_back(mk(3'd3,1'b0,1'b0,1'b0,is_lw,is_sw,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(0);
               end
               exp_q.push_back(mk(3'd3,is_sw,1'b0,1'b0,is_lw,is_sw,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(1);
            end
            if (in.kind != K_BEQ && !is_sw)
               exp_q.push_back(mk(3'd4,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,
                                  (in.kind == K_R) ? 2'b00 : 2'b01, is_lw ? 2'b01 : 2'b00, 1'b0));
            if (in.kind != K_BEQ && !is_sw) mr_q.push_back(-1);
         end
      endcase
   endtask

   // Drive up to 'limit' expected cycles from exp_q and compare each one; reports first PCWrite cycle.
   task automatic run_q(input string name, input logic [5:0] op, input logic [5:0] f,
                        input logic z, input int limit, output int seen);
      int cyc;
      cyc = (limit < exp_q.size()) ? limit : exp_q.size();
      seen = 0;
      for (int c = 0; c < cyc; c++) begin
         @(negedge clk);
         bus.Op = op; bus.Funct = f; bus.Zero = z;
         bus.mem_ready = (mr_q[c] < 0) ? 1'($urandom_range(0, 1)) : mr_q[c][0];
         #1;
         checks++;
         if (obs() !== exp_q[c]) begin
            failures++;
            $display("FAIL %s cycle %0d ctrl: got %h expected %h", name, c, obs(), exp_q[c]);
         end
         checks++;
         if (bus.instr_cnt !== exp_cnt()) begin
            failures++;
            $display("FAIL %s cycle %0d instr_cnt: got %0d expected %0d", name, c, bus.instr_cnt, exp_cnt());
         end
         if (exp_q[c][17]) cnt_model = cnt_model + 32'd1;
         if (bus.PCWrite === 1'b1 && seen == 0) seen = c + 1;
      end
   endtask

   task automatic run_ins(input ins_t in, input logic z, input int n);
      int seen;
      build(in, z, n);
      run_q(in.nm, in.op, in.funct, z, 1000, seen);
      checks++;
      if (seen !== latency(in.kind, n)) begin
         failures++;
         $display("FAIL %s latency: got %0d expected %0d", in.nm, seen, latency(in.kind, n));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #2 rstn = 1'b1;
      cnt_model = 32'd0;
   endtask

   task automatic test_reset();
      bus.Op = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (obs() !== mk(3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)) begin
         failures++;
         $display("FAIL reset ctrl: got %h expected all-zero FETCH", obs());
      end
      checks++;
      if (bus.instr_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset instr_cnt: got %0d expected 0", bus.instr_cnt);
      end
      @(posedge clk);
      #2 rstn = 1'b1;
      cnt_model = 32'd0;
   endtask

   task automatic test_directed();
      run_ins(find("add"), 1'b0, 0);
      run_ins(find("lw"), 1'b1, 2);
      run_ins(find("beq"), 1'b1, 0);
      run_ins(find("beq"), 1'b0, 0);
      run_ins(find("jal"), 1'b0, 0);
   endtask

   task automatic test_halt();
      logic [5:0] ops[2];
      logic [5:0] fns[2];
      int seen;
      ops[0] = 6'b111111; fns[0] = 6'($urandom);
      ops[1] = 6'b000000; fns[1] = 6'b000000;
      for (int k = 0; k < 2; k++) begin
         exp_q.delete(); mr_q.delete();
         exp_q.push_back(mk(3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(-1);
         exp_q.push_back(mk(3'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)); mr_q.push_back(-1);
         for (int i = 0; i < 10; i++) begin
            exp_q.push_back(mk(3'd7,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b1)); mr_q.push_back(-1);
         end
         run_q("halt", ops[k], fns[k], 1'($urandom_range(0, 1)), 1000, seen);
         @(negedge clk);
         rstn = 1'b0;
         @(posedge clk);
         #2 rstn = 1'b1;
         #1;
         checks++;
         if (obs() !== mk(3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,2'b00,2'b00,2'b00,1'b0)) begin
            failures++;
            $display("FAIL halt_reset ctrl: got %h expected FETCH with halted=0", obs());
         end
         cnt_model = 32'd0;
      end
   endtask

   task automatic test_perf_cnt();
      logic [31:0] want;
      do_reset();
      run_ins(find("sw"), 1'b0, $urandom_range(0, 3));
      run_ins(find("addi"), 1'b0, 0);
      run_ins(find("j"), 1'b0, 0);
      @(posedge clk); #1;
`ifdef MC_CTRL_PERF_CNT_EN
      want = 32'd3;
`else
      want = 32'd0;
`endif
      checks++;
      if (bus.instr_cnt !== want) begin
         failures++;
         $display("FAIL perf_cnt: got %0d expected %0d", bus.instr_cnt, want);
      end
   endtask

   task automatic test_reset_mid_mem();
      int seen;
      ins_t s;
      s = find("sw");
      build(s, 1'b0, 5);
      run_q("sw_mid", s.op, s.funct, 1'b0, 4, seen);
      @(negedge clk);
      rstn = 1'b0; bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.MemWrite !== 1'b0 || bus.state !== 3'd3) begin
         failures++;
         $display("FAIL mid_mem_rst: MemWrite=%b state=%0d expected MemWrite=0 state=3", bus.MemWrite, bus.state);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.state !== 3'd0 || bus.instr_cnt !== 32'd0 || bus.MemWrite !== 1'b0) begin
         failures++;
         $display("FAIL mid_mem_after: state=%0d cnt=%0d MemWrite=%b expected 0/0/0", bus.state, bus.instr_cnt, bus.MemWrite);
      end
      #1 rstn = 1'b1;
      cnt_model = 32'd0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++)
         run_ins(tbl[$urandom_range(0, tbl.size() - 1)], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if (bus.state !== 3'd0 || bus.instr_cnt !== exp_cnt()) begin
         failures++;
         $display("FAIL random_end: state=%0d cnt=%0d expected 0/%0d", bus.state, bus.instr_cnt, exp_cnt());
      end
   endtask

   initial begin
      add_ins("add",  6'b000000, 6'b100000, K_R, 4'b0001, 1'b0, 1'b0);
      add_ins("addu", 6'b000000, 6'b100001, K_R, 4'b0001, 1'b0, 1'b0);
      add_ins("sub",  6'b000000, 6'b100010, K_R, 4'b0010, 1'b0, 1'b0);
      add_ins("subu", 6'b000000, 6'b100011, K_R, 4'b0010, 1'b0, 1'b0);
      add_ins("and",  6'b000000, 6'b100100, K_R, 4'b0011, 1'b0, 1'b0);
      add_ins("or",   6'b000000, 6'b100101, K_R, 4'b0100, 1'b0, 1'b0);
      add_ins("nor",  6'b000000, 6'b100111, K_R, 4'b0111, 1'b0, 1'b0);
      add_ins("slt",  6'b000000, 6'b101010, K_R, 4'b0101, 1'b0, 1'b0);
      add_ins("sltu", 6'b000000, 6'b101011, K_R, 4'b0110, 1'b0, 1'b0);
      add_ins("jr",   6'b000000, 6'b001000, K_JR,   4'b0000, 1'b0, 1'b0);
      add_ins("jalr", 6'b000000, 6'b001001, K_JALR, 4'b0000, 1'b0, 1'b0);
      add_ins("addi", 6'b001000, 6'($urandom), K_I, 4'b0001, 1'b1, 1'b1);
      add_ins("ori",  6'b001101, 6'($urandom), K_I, 4'b0100, 1'b1, 1'b0);
      add_ins("andi", 6'b001100, 6'($urandom), K_I, 4'b0011, 1'b1, 1'b1);
      add_ins("slti", 6'b001010, 6'($urandom), K_I, 4'b0101, 1'b1, 1'b1);
      add_ins("lui",  6'b001111, 6'($urandom), K_I, 4'b1001, 1'b1, 1'b1);
      add_ins("lw",   6'b100011, 6'($urandom), K_LW,  4'b0001, 1'b1, 1'b1);
      add_ins("sw",   6'b101011, 6'($urandom), K_SW,  4'b0001, 1'b1, 1'b1);
      add_ins("beq",  6'b000100, 6'($urandom), K_BEQ, 4'b0010, 1'b0, 1'b0);
      add_ins("j",    6'b000010, 6'($urandom), K_J,   4'b0000, 1'b0, 1'b0);
      add_ins("jal",  6'b000011, 6'($urandom), K_JAL, 4'b0000, 1'b0, 1'b0);

      test_reset();
      test_directed();
      test_halt();
      test_perf_cnt();
      test_reset_mid_mem();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
